// File: rtl/ppg_fifo_pkg.sv
// ppg_fifo_pkg: overflow policy encodings and default margins shared with the BPM controller
package ppg_fifo_pkg;
  localparam logic OVF_REJECT    = 1'b0;
  localparam logic OVF_OVERWRITE = 1'b1;
  localparam int   DROP_W_DEF    = 16;
  localparam int   AF_MARGIN     = 4;
  localparam int   AE_MARGIN     = 4;
endpackage

// File: rtl/ppg_sample_fifo_if.sv
// ppg_sample_fifo_if: sample write/read, overflow control and status bundle for ppg_sample_fifo
interface ppg_sample_fifo_if
  import ppg_fifo_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DEPTH  = 32,
  parameter int DROP_W = DROP_W_DEF
);
  localparam int LW = $clog2(DEPTH) + 1;
  logic              wr_en;
  logic [WIDTH-1:0]  Data_in;
  logic              rd_en;
  logic [WIDTH-1:0]  Data_out;
  logic              rd_valid;
  logic              ovf_mode;
  logic              drop_clr;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [LW-1:0]     level;
  logic [DROP_W-1:0] drop_cnt;
  modport master (
    output wr_en, Data_in, rd_en, ovf_mode, drop_clr,
    input  Data_out, rd_valid, full, empty, almost_full, almost_empty, level, drop_cnt
  );
  modport slave (
    input  wr_en, Data_in, rd_en, ovf_mode, drop_clr,
    output Data_out, rd_valid, full, empty, almost_full, almost_empty, level, drop_cnt
  );
endinterface

// File: rtl/ppg_fifo_mem.sv
// ppg_fifo_mem: dual-port register array, synchronous write, registered read port
module ppg_fifo_mem #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  // read sees the pre-write contents, so a full read+write returns the oldest entry
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
endmodule

// File: rtl/ppg_sample_fifo.sv
// ppg_sample_fifo: ADC sample FIFO with selectable overflow policy, level flags and drop counter
module ppg_sample_fifo
  import ppg_fifo_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - AF_MARGIN,
  parameter int AE_LEVEL = AE_MARGIN,
  parameter int DROP_W   = DROP_W_DEF
) (
  input logic               clk,
  input logic               reset_n,
  ppg_sample_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_L   = LW'(AE_LEVEL);
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic [DROP_W-1:0] drop_cnt;
  logic              rd_valid;
  logic              full, empty, rd_ok, wr_fit, drop, ovw, mem_we, rd_adv;
  assign full   = level == FULL_L;
  assign empty  = level == '0;
  assign rd_ok  = bus.rd_en && !empty;
  assign wr_fit = bus.wr_en && (!full || rd_ok);
  assign drop   = bus.wr_en && full && !rd_ok;
  assign ovw    = drop && (bus.ovf_mode == OVF_OVERWRITE);
  assign mem_we = wr_fit || ovw;
  assign rd_adv = rd_ok || ovw;
  ppg_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (mem_we),
    .wr_addr (wr_ptr),
    .wr_data (bus.Data_in),
    .re      (rd_ok),
    .rd_addr (rd_ptr),
    .rd_data (bus.Data_out)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(mem_we);
      rd_ptr   <= rd_ptr + AW'(rd_adv);
      level    <= (wr_fit && !rd_ok) ? level + 1'b1 : (rd_ok && !wr_fit) ? level - 1'b1 : level;
      rd_valid <= rd_ok;
      drop_cnt <= bus.drop_clr ? '0 : (drop && !(&drop_cnt)) ? drop_cnt + 1'b1 : drop_cnt;
    end
  assign bus.rd_valid     = rd_valid;
  assign bus.level        = level;
  assign bus.drop_cnt     = drop_cnt;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = level >= AF_L;
  assign bus.almost_empty = level <= AE_L;
endmodule

// File: tb/tb_ppg_sample_fifo.sv
// tb_ppg_sample_fifo: directed checks of fill/drain, both overflow policies, boundaries, async reset, saturation
module tb_ppg_sample_fifo;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  ppg_sample_fifo_if #(.WIDTH(10), .DEPTH(32), .DROP_W(16)) bus ();
  ppg_sample_fifo_if #(.WIDTH(10), .DEPTH(32), .DROP_W(4))  bus2 ();
  ppg_sample_fifo #(.WIDTH(10), .DEPTH(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  ppg_sample_fifo #(.WIDTH(10), .DEPTH(32), .DROP_W(4)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wr_en = 0; bus.rd_en = 0; bus.Data_in = '0; bus.ovf_mode = 0; bus.drop_clr = 0;
    bus2.wr_en = 0; bus2.rd_en = 0; bus2.Data_in = '0; bus2.ovf_mode = 0; bus2.drop_clr = 0;
    #2;
    chk("rst_empty", bus.empty, 1);
    chk("rst_ae", bus.almost_empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_af", bus.almost_full, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_dout", bus.Data_out, 0);
    chk("rst_drop", bus.drop_cnt, 0);
    tick(); tick();
    reset_n = 1;
    // fill and drain
    for (int i = 0; i < 32; i++) begin
      bus.wr_en = 1; bus.Data_in = 10'(i);
      tick();
      chk("fill_level", bus.level, i + 1);
      chk("fill_af", bus.almost_full, (i + 1) >= 28);
      chk("fill_full", bus.full, (i + 1) == 32);
      chk("fill_ae", bus.almost_empty, (i + 1) <= 4);
    end
    bus.wr_en = 0;
    for (int i = 0; i < 32; i++) begin
      bus.rd_en = 1;
      tick();
      chk("drain_valid", bus.rd_valid, 1);
      chk("drain_data", bus.Data_out, i);
      chk("drain_level", bus.level, 31 - i);
      chk("drain_ae", bus.almost_empty, (31 - i) <= 4);
      chk("drain_empty", bus.empty, i == 31);
    end
    tick();
    chk("underflow_valid", bus.rd_valid, 0);
    chk("underflow_hold", bus.Data_out, 31);
    chk("underflow_level", bus.level, 0);
    bus.rd_en = 0;
    // overwrite-oldest overflow
    bus.ovf_mode = 1;
    for (int i = 0; i < 36; i++) begin
      bus.wr_en = 1; bus.Data_in = 10'(i);
      tick();
    end
    bus.wr_en = 0;
    chk("ovw_level", bus.level, 32);
    chk("ovw_drop", bus.drop_cnt, 4);
    for (int i = 0; i < 32; i++) begin
      bus.rd_en = 1;
      tick();
      chk("ovw_data", bus.Data_out, i + 4);
    end
    bus.rd_en = 0;
    chk("ovw_empty", bus.empty, 1);
    bus.drop_clr = 1;
    tick();
    bus.drop_clr = 0;
    chk("clr_drop", bus.drop_cnt, 0);
    // reject-newest overflow
    bus.ovf_mode = 0;
    for (int i = 0; i < 36; i++) begin
      bus.wr_en = 1; bus.Data_in = 10'(i);
      tick();
    end
    chk("rej_level", bus.level, 32);
    chk("rej_drop", bus.drop_cnt, 4);
    bus.drop_clr = 1;
    tick();
    chk("clr_priority", bus.drop_cnt, 0);
    chk("clr_level", bus.level, 32);
    bus.drop_clr = 0; bus.wr_en = 0;
    for (int i = 0; i < 32; i++) begin
      bus.rd_en = 1;
      tick();
      chk("rej_data", bus.Data_out, i);
    end
    bus.rd_en = 0;
    // simultaneous read+write when full
    for (int i = 0; i < 32; i++) begin
      bus.wr_en = 1; bus.Data_in = 10'(i + 40);
      tick();
    end
    bus.wr_en = 1; bus.rd_en = 1; bus.Data_in = 10'd99;
    tick();
    chk("fullrw_valid", bus.rd_valid, 1);
    chk("fullrw_data", bus.Data_out, 40);
    chk("fullrw_level", bus.level, 32);
    chk("fullrw_drop", bus.drop_cnt, 0);
    bus.wr_en = 0;
    for (int i = 1; i < 33; i++) begin
      tick();
      chk("fullrw_drain", bus.Data_out, (i == 32) ? 99 : i + 40);
    end
    chk("fullrw_empty", bus.empty, 1);
    // simultaneous read+write when empty: no fall-through
    bus.wr_en = 1; bus.rd_en = 1; bus.Data_in = 10'd7;
    tick();
    chk("emptyrw_level", bus.level, 1);
    chk("emptyrw_valid", bus.rd_valid, 0);
    bus.wr_en = 0;
    tick();
    chk("emptyrw_read", bus.Data_out, 7);
    chk("emptyrw_rvalid", bus.rd_valid, 1);
    bus.rd_en = 0;
    // asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1; bus.Data_in = 10'(i + 10);
      tick();
    end
    bus.rd_en = 1; bus.Data_in = 10'd13;
    tick();
    chk("pre_rst_data", bus.Data_out, 10);
    chk("pre_rst_level", bus.level, 3);
    #2 reset_n = 0;
    #1;
    chk("arst_data", bus.Data_out, 0);
    chk("arst_valid", bus.rd_valid, 0);
    chk("arst_level", bus.level, 0);
    chk("arst_empty", bus.empty, 1);
    chk("arst_ae", bus.almost_empty, 1);
    bus.wr_en = 0; bus.rd_en = 0;
    tick();
    reset_n = 1;
    bus.rd_en = 1;
    tick();
    chk("post_rst_valid", bus.rd_valid, 0);
    chk("post_rst_empty", bus.empty, 1);
    bus.rd_en = 0;
    // drop counter saturation on the narrow-counter instance
    for (int i = 0; i < 52; i++) begin
      bus2.wr_en = 1; bus2.Data_in = 10'(i);
      tick();
      if (i == 46) chk("sat_at15", bus2.drop_cnt, 15);
    end
    bus2.wr_en = 0;
    chk("sat_hold", bus2.drop_cnt, 15);
    chk("sat_level", bus2.level, 32);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ppg_sample_fifo.md
Name: ppg_sample_fifo

Overview:
- Parametrised successor to the PPG interface sample FIFO. Buffers ADC samples between the PPG front-end and the BPM processing chain.
- New over the previous generation: run-time overflow policy (discard-oldest or reject-newest), programmable almost-full/almost-empty flags, fill-level output, registered read-valid strobe, and a saturating drop counter.

Parameters:
- WIDTH, 10, sample width in bits.
- DEPTH, 32, number of entries; power of two, >= 4.
- AF_LEVEL, DEPTH-4, almost_full asserts when level >= AF_LEVEL.
- AE_LEVEL, 4, almost_empty asserts when level <= AE_LEVEL.
- DROP_W, 16, drop counter width.

Ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- Data_in  in  WIDTH  write data.
- rd_en  in  1  read request.
- Data_out  out  WIDTH  read data, registered.
- rd_valid  out  1  one-cycle strobe: Data_out updated this cycle.
- ovf_mode  in  1  0 = reject newest when full; 1 = discard oldest when full.
- drop_clr  in  1  synchronous clear of drop_cnt.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AF_LEVEL.
- almost_empty  out  1  level <= AE_LEVEL.
- level  out  $clog2(DEPTH)+1  current occupancy.
- drop_cnt  out  DROP_W  samples lost to overflow, saturating.

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-low, reset_n.
- Reset: wr_ptr, rd_ptr, level, Data_out, rd_valid and drop_cnt clear to 0 immediately on reset_n low.
  - Outputs during reset: empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all contents. The first post-reset edge behaves as from empty.
- Pointers: $clog2(DEPTH) bits, natural wrap at DEPTH. level is the explicit occupancy register.
- Flags are combinational decodes of the level register only; no input-to-output combinational path.
- Read: rd_en && !empty at edge N:
  - Data_out <= mem[rd_ptr]; rd_ptr++; rd_valid=1 for cycle N+1.
  - Otherwise rd_valid=0 and Data_out holds its value.
  - rd_en when empty is ignored; no underflow error.
- Write, not full: mem[wr_ptr] <= Data_in; wr_ptr++.
- Write when full, no accepted read:
  - ovf_mode=1: write stored, wr_ptr++, rd_ptr++ (oldest lost), level unchanged, drop_cnt++.
  - ovf_mode=0: write ignored, pointers and level unchanged, drop_cnt++.
- Simultaneous wr_en and accepted read:
  - Both take effect, level unchanged, no drop, in either mode.
  - When full: the read returns the oldest entry and the write takes the freed slot.
- Write and read both asserted when empty: write accepted, read ignored (no fall-through), level becomes 1.
- Level update: +1 on write-only, -1 on read-only, unchanged on both, and unchanged on an overflowed write.
- drop_cnt:
  - Saturates at all-ones.
  - drop_clr has priority over an increment in the same cycle.
- ovf_mode may change at any cycle and applies from that edge.
- Latency: a write at edge N is readable with rd_en at edge N+1; data appears on Data_out after edge N+1.

Decomposition:
- Shared package ppg_fifo_pkg holds:
  - OVF_REJECT=1'b0 and OVF_OVERWRITE=1'b1.
  - Default DROP_W.
  - Default AF/AE margins, which the BPM controller also uses.
- Sub-module ppg_fifo_mem: simple dual-port register array with synchronous write and synchronous registered read, parameters WIDTH/DEPTH.
- Pointers, level, flags and the drop counter stay in ppg_sample_fifo.

Test Plan:
- Fill and drain: write 0..31 back-to-back, then read 32 times.
  - Outputs 0..31 in order, each with rd_valid.
  - full at level 32; almost_full from level 28; almost_empty at levels 4..0; empty at the end.
- Overwrite overflow: ovf_mode=1, write 0..35 with no reads.
  - level stays 32, drop_cnt=4.
  - Subsequent reads return 4..35.
- Reject overflow: ovf_mode=0, write 0..35.
  - drop_cnt=4; reads return 0..31.
  - drop_clr pulse sets drop_cnt=0 on the next cycle.
- Simultaneous at boundaries:
  - Full FIFO with wr_en+rd_en writing 99: read returns the oldest, level stays 32, drop_cnt unchanged.
  - Empty FIFO with wr_en+rd_en: level becomes 1, rd_valid=0.
- Async reset: assert reset_n low mid-burst between clock edges.
  - Outputs clear without a clock edge.
  - After release, first read attempt gives rd_valid=0 and empty=1.
- Saturation: DROP_W=4 override, force 20 rejected writes.
  - drop_cnt holds at 15.
